// File: rtl/present_arbiter.sv
// present_arbiter: round-robin two-requester front end for a PRESENT cipher core with timeout abort.
module present_arbiter #(
  parameter int TIMEOUT = 64,
  parameter bit BITREV = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [63:0] req0_state,
  input  logic [63:0] req1_state,
  input  logic [79:0] req0_key,
  input  logic [79:0] req1_key,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        core_start,
  output logic [63:0] core_state,
  output logic [79:0] core_key,
  input  logic        core_end,
  input  logic [63:0] core_result
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2, DRAIN = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic last, gnt, pick;
  logic [63:0] rev, result;
  for (genvar i = 0; i < 64; i++) begin : g_rev
    assign rev[i] = core_result[63-i];
  end
  assign result = BITREV ? rev : core_result;
  // on a tie the requester not granted last wins
  assign pick = (req0_valid && req1_valid) ? ~last : req1_valid;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      timer       <= '0;
      last        <= 1'b1;
      gnt         <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      core_start  <= 1'b0;
      core_state  <= '0;
      core_key    <= '0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          gnt        <= pick;
          core_state <= pick ? req1_state : req0_state;
          core_key   <= pick ? req1_key : req0_key;
          core_start <= 1'b1;
          timer      <= '0;
          req0_ready <= ~pick;
          req1_ready <= pick;
          state      <= RUN;
        end
        RUN: begin
          timer <= timer + 1'b1;
          if (core_end) begin
            resp_data  <= result;
            resp_err   <= 1'b0;
            core_start <= 1'b0;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            core_start <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp0_valid <= ~gnt;
          resp1_valid <= gnt;
          last        <= gnt;
          state       <= DRAIN;
        end
        DRAIN: if (!core_end) state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/present_arbiter.md
PRESENT_ARBITER -- requirements
Module: present_arbiter

Parameters
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- TIMEOUT, 64, max cycles in RUN waiting for core_end before abort.
- BITREV, 1, 1 = bit-reverse core_result before returning (resp_data[k] = core_result[63-k]); 0 = pass through.

Interface
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- sys_clk  in  1  single clock; all state on rising edge.
- sys_rst  in  1  reset, asynchronous and active-high.
- req0_valid / req1_valid  in  1  requester N has a job.
- req0_state / req1_state  in  64  plaintext block.
- req0_key / req1_key  in  80  cipher key.
- req0_ready / req1_ready  out  1  one-cycle pulse: job captured.
- resp0_valid / resp1_valid  out  1  one-cycle pulse: result available.
- resp_data  out  64  result of the job whose resp valid is high.
- resp_err  out  1  valid with resp valid; 1 = timeout abort.
- core_start  out  1  level start to the cipher core.
- core_state  out  64  captured plaintext to the core.
- core_key  out  80  captured key to the core.
- core_end  in  1  core done level.
- core_result  in  64  core output, valid while core_end=1.

Function
REQ-003 FSM states SHALL be IDLE, RUN, RESP and DRAIN.
REQ-004 IDLE: when any req valid=1 at an edge, grant one requester, load core_state/core_key from it, set core_start=1, clear the timer and enter RUN; with no request, stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: one request wins; on a tie, the requester not granted last wins; after reset, requester 0 wins ties.
REQ-006 reqN_ready SHALL pulse high for exactly the one cycle after the capture edge, for the granted N only.
- Requester holds valid/data until it sees ready, then may drop valid.
REQ-007 RUN: core_start SHALL stay 1; the timer increments every cycle.
REQ-008 RUN, core_end=1: register resp_data (per BITREV), set resp_err=0, set core_start=0, enter RESP.
REQ-009 RUN, timer reaches TIMEOUT-1 with core_end=0: set resp_data=0, resp_err=1, core_start=0, enter RESP.
- If core_end=1 on that same edge, completion wins over timeout.
REQ-010 RESP: respN_valid SHALL be high for one cycle for the granted N; resp_data/resp_err are stable through that cycle; update the last-grant pointer; enter DRAIN.
REQ-011 DRAIN: wait until core_end=0, then enter IDLE; no grant is made in DRAIN.
REQ-012 Latency: capture edge to respN_valid SHALL be (core latency in cycles from core_start rise to core_end) + 2 cycles.
REQ-013 Requests arriving in RUN/RESP/DRAIN SHALL not be lost; they wait, held valid by the requester, and are served from IDLE.
REQ-014 core_state/core_key SHALL hold their values from capture until the next capture.

Reset
REQ-015 While sys_rst=1: FSM=IDLE, timer=0, last-grant pointer=1 (so requester 0 wins the first tie), all ready/valid/err/core_start=0, resp_data/core_state/core_key=0.
REQ-016 Reset asserted mid-job SHALL abort it immediately with no response pulse; after release, pending requests are served afresh.

Verification
REQ-017 The bench SHALL cover these directed scenarios, with a core model of fixed 32-cycle latency:
- Single job: req0 state=0, key=0, model returns 64'h5579C1387B228445 -> resp0_valid once, resp_err=0, resp_data=bit-reverse of it (BITREV=1); latency 34.
- Tie: req0 and req1 held valid from reset release -> order req0, req1, req0, req1...; never two grants in flight.
- Timeout: model never raises core_end, TIMEOUT=64 -> resp_err=1 and resp_data=0 after 64 RUN cycles; core_start drops; next request served.
- Stuck end: core_end held high 5 cycles after the job -> FSM stays in DRAIN until core_end falls; no new core_start in DRAIN.
- Mid-job reset: sys_rst pulsed in RUN -> all outputs 0 asynchronously; no resp pulse; req1 pending is served after release.
- BITREV=0 with key/state all-ones, model returns 64'h3333DCD3213210D2 -> resp_data equals that value unchanged.
